i2s_codec_port: RTL

Bidirectional I2S slave port to the audio codec once the SPI register configurator has finished (codec is I2S master, I2S format, 24-bit words). It recovers the codec-driven BCLK/LRCLK in the system clock domain. It deserialises ADC data into parallel left/right samples and serialises a parallel DAC sample pair onto DACDAT. It sits directly downstream of the configurator: the configurator's `done` drives `enable`, and the DSP fabric sits on the parallel side.

---
 rtl/codec_pkg.sv | 9 +
 rtl/sync_edge.sv | 27 ++
 rtl/i2s_codec_port.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/codec_pkg.sv
// codec_pkg: shared word length and state encoding for the codec-side blocks
package codec_pkg;
    localparam int AUDIO_WIDTH = 24;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RUN   = 2'd2
    } codec_state_e;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchroniser with a history flop and registered rise/fall strobes
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync;
    // q is the history flop, so level and strobes share STAGES+1 cycles of latency
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
            q    <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= (sync << 1) | STAGES'(d);
            q    <= sync[STAGES-1];
            rise <= sync[STAGES-1] & ~q;
            fall <= ~sync[STAGES-1] & q;
        end
    end
endmodule

// File: rtl/i2s_codec_port.sv
// i2s_codec_port: I2S slave port, ADC deserialiser and DAC serialiser with frame alignment
module i2s_codec_port
    import codec_pkg::*;
#(
    parameter int WIDTH       = AUDIO_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             codec_bclk,
    input  logic             codec_lrclk,
    input  logic             codec_adcdat,
    output logic             codec_dacdat,
    output logic [WIDTH-1:0] adc_left,
    output logic [WIDTH-1:0] adc_right,
    output logic             adc_valid,
    input  logic [WIDTH-1:0] dac_left,
    input  logic [WIDTH-1:0] dac_right,
    input  logic             dac_valid,
    output logic             dac_req,
    output logic             locked,
    output logic             frame_error
);
    localparam int CW = $clog2(WIDTH + 2);
    localparam int AW = SYNC_STAGES + 1;
    localparam logic [CW-1:0] CNT_W    = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH + 1);

    codec_state_e state_q, state_d;
    logic bclk_level_unused, bclk_rise, bclk_fall;
    logic lr_level, lr_rise, lr_fall, lr_edge;
    logic [AW-1:0] adc_sync;
    logic adc_bit;
    logic active, capture, load_frame, truncated;
    logic [CW-1:0] bit_cnt;
    logic [WIDTH-2:0] adc_sr;
    logic [WIDTH-1:0] adc_word, stage_l;
    logic left_ok;
    logic [WIDTH-1:0] hold_l, hold_r, tx_l, tx_r, tx_sr;

    sync_edge #(.STAGES(SYNC_STAGES)) u_bclk (
        .clk(clk), .reset(reset), .d(codec_bclk),
        .q(bclk_level_unused), .rise(bclk_rise), .fall(bclk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_lrclk (
        .clk(clk), .reset(reset), .d(codec_lrclk),
        .q(lr_level), .rise(lr_rise), .fall(lr_fall)
    );

    // data takes the same SYNC_STAGES+1 path as the clock strobes
    always_ff @(posedge clk) begin
        if (reset)
            adc_sync <= '0;
        else
            adc_sync <= (adc_sync << 1) | AW'(codec_adcdat);
    end

    assign adc_bit  = adc_sync[AW-1];
    assign adc_word = {adc_sr, adc_bit};

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = !enable                               ? ST_IDLE  :
                  state_q == ST_IDLE                    ? ST_ALIGN :
                  (state_q == ST_ALIGN && lr_fall)      ? ST_RUN   : state_q;
    end

    always_comb begin
        lr_edge    = lr_rise | lr_fall;
        locked     = state_q == ST_RUN;
        active     = enable && state_q != ST_IDLE;
        capture    = enable && state_q == ST_RUN;
        load_frame = active && lr_fall;
        truncated  = capture && lr_edge && bit_cnt != '0 && bit_cnt <= CNT_W;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt      <= '0;
            adc_sr       <= '0;
            stage_l      <= '0;
            left_ok      <= 1'b0;
            adc_left     <= '0;
            adc_right    <= '0;
            adc_valid    <= 1'b0;
            hold_l       <= '0;
            hold_r       <= '0;
            tx_l         <= '0;
            tx_r         <= '0;
            tx_sr        <= '0;
            codec_dacdat <= 1'b0;
            dac_req      <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            adc_valid <= 1'b0;
            dac_req   <= 1'b0;
            if (dac_valid) begin
                hold_l <= dac_left;
                hold_r <= dac_right;
            end
            if (!active) begin
                bit_cnt      <= '0;
                adc_sr       <= '0;
                left_ok      <= 1'b0;
                tx_sr        <= '0;
                codec_dacdat <= 1'b0;
                frame_error  <= 1'b0;
            end else begin
                if (lr_edge)
                    bit_cnt <= '0;
                else if (bclk_rise && bit_cnt != CNT_LAST)
                    bit_cnt <= bit_cnt + CW'(1);
                if (lr_fall)
                    left_ok <= 1'b0;
                // count 0 is the I2S delay slot; counts past WIDTH are padding
                if (capture && bclk_rise && bit_cnt != '0 && bit_cnt <= CNT_W) begin
                    adc_sr <= adc_word[WIDTH-2:0];
                    if (bit_cnt == CNT_W && !lr_level) begin
                        stage_l <= adc_word;
                        left_ok <= 1'b1;
                    end else if (bit_cnt == CNT_W && left_ok) begin
                        adc_left  <= stage_l;
                        adc_right <= adc_word;
                        adc_valid <= 1'b1;
                    end
                end
                if (truncated)
                    frame_error <= 1'b1;
                if (load_frame) begin
                    tx_l    <= hold_l;
                    tx_r    <= hold_r;
                    dac_req <= 1'b1;
                end
                // the left word is taken straight from the holding pair since tx_l updates this edge
                if (lr_edge)
                    tx_sr <= lr_fall ? hold_l : tx_r;
                else if (bclk_fall)
                    tx_sr <= tx_sr << 1;
                if (bclk_fall)
                    codec_dacdat <= locked & tx_sr[WIDTH-1];
            end
        end
    end
endmodule
